// File: rtl/wb_line_fetcher_if.sv
// Wishbone read bus plus pixel-stream handshake shared by the line fetcher and its neighbours.
// The fetcher takes the master view; bus responder and pixel consumer take the slave view.
interface wb_line_fetcher_if;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic [31:0] o_wb_addr;
   logic        o_wb_we;
   logic [31:0] i_wb_data;
   logic        i_wb_stall;
   logic        i_wb_ack;
   logic [31:0] o_pix_data;
   logic        o_pix_valid;
   logic        i_pix_ready;

   modport master (
      output o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_we,
      input  i_wb_data, i_wb_stall, i_wb_ack,
      output o_pix_data, o_pix_valid,
      input  i_pix_ready
   );

   modport slave (
      input  o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_we,
      output i_wb_data, i_wb_stall, i_wb_ack,
      input  o_pix_data, o_pix_valid,
      output i_pix_ready
   );
endinterface

// File: rtl/wb_line_fetcher.sv
// Pipelined Wishbone reader that streams one video line into a show-ahead FIFO.
// Define LINE_FETCH_ERR_EN to add i_wb_err / o_err bus-error abort handling.
module wb_line_fetcher #(
   parameter int WORDS_PER_LINE = 160,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_start,
   input  logic [31:0] i_base_addr,
   output logic        o_busy,
   output logic        o_done,
`ifdef LINE_FETCH_ERR_EN
   input  logic        i_wb_err,
   output logic        o_err,
`endif
   wb_line_fetcher_if.master bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t        state, state_next;
   logic          cyc, cyc_next, stb, stb_next, busy_next, done_next;
   logic [31:0]   addr, addr_next;
   logic [11:0]   req_left, req_left_next, ack_left, ack_left_next;
   logic [CW-1:0] in_flight, in_flight_next, count, count_next;
   logic [CW:0]   credit_sum;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   mem [FIFO_DEPTH];
   logic          accept, ack, pop, err_hit;

   assign accept = stb & ~bus.i_wb_stall;
   // Stray acks outside a cycle or with nothing outstanding must not reach the FIFO.
   assign ack    = cyc & bus.i_wb_ack & (in_flight != '0);
   assign pop    = (count != '0) & bus.i_pix_ready;
`ifdef LINE_FETCH_ERR_EN
   assign err_hit = cyc & i_wb_err;
`else
   assign err_hit = 1'b0;
`endif

   assign count_next = count + CW'(ack) - CW'(pop);
   assign credit_sum = {1'b0, in_flight_next} + {1'b0, count_next};

   // Next-state logic; a new strobe is only raised when the FIFO can absorb every outstanding response.
   always_comb begin
      state_next     = state;
      cyc_next       = cyc;
      stb_next       = stb;
      addr_next      = addr;
      req_left_next  = req_left;
      ack_left_next  = ack_left;
      busy_next      = o_busy;
      done_next      = 1'b0;
      in_flight_next = in_flight + CW'(accept) - CW'(ack);
      unique case (state)
         IDLE: begin
            if (i_start) begin
               state_next    = REQ;
               cyc_next      = 1'b1;
               busy_next     = 1'b1;
               addr_next     = {i_base_addr[31:2], 2'b00};
               req_left_next = 12'(WORDS_PER_LINE);
               ack_left_next = 12'(WORDS_PER_LINE);
               stb_next      = credit_sum < DEPTH_C;
            end
         end
         REQ: begin
            if (accept) begin
               addr_next     = addr + 32'd4;
               req_left_next = req_left - 12'd1;
            end
            if (!stb || accept) begin
               stb_next = (req_left_next != 12'd0) && (credit_sum < DEPTH_C);
            end
            if (accept && req_left == 12'd1) begin
               state_next = DRAIN;
            end
            if (ack) begin
               ack_left_next = ack_left - 12'd1;
            end
         end
         DRAIN: begin
            if (ack) begin
               ack_left_next = ack_left - 12'd1;
               if (ack_left == 12'd1) begin
                  state_next = IDLE;
                  cyc_next   = 1'b0;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            cyc_next   = 1'b0;
            stb_next   = 1'b0;
            busy_next  = 1'b0;
         end
      endcase
      if (err_hit) begin
         state_next     = IDLE;
         cyc_next       = 1'b0;
         stb_next       = 1'b0;
         busy_next      = 1'b0;
         done_next      = 1'b0;
         in_flight_next = '0;
      end
   end

   // State register and FIFO bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cyc       <= 1'b0;
         stb       <= 1'b0;
         addr      <= '0;
         req_left  <= '0;
         ack_left  <= '0;
         in_flight <= '0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         state     <= state_next;
         cyc       <= cyc_next;
         stb       <= stb_next;
         addr      <= addr_next;
         req_left  <= req_left_next;
         ack_left  <= ack_left_next;
         in_flight <= in_flight_next;
         count     <= count_next;
         o_busy    <= busy_next;
         o_done    <= done_next;
         if (ack) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
   end

`ifdef LINE_FETCH_ERR_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) o_err <= 1'b0;
      else          o_err <= err_hit;
   end
`endif

   always_ff @(posedge clk) begin
      if (ack) mem[wr_ptr] <= bus.i_wb_data;
   end

   assign bus.o_wb_cyc    = cyc;
   assign bus.o_wb_stb    = stb;
   assign bus.o_wb_addr   = addr;
   assign bus.o_wb_we     = 1'b0;
   assign bus.o_pix_valid = (count != '0);
   assign bus.o_pix_data  = (count != '0) ? mem[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_wb_line_fetcher.sv
// Directed bench for wb_line_fetcher: zero-wait, stalling and backpressured fetches, wrap, restart and reset.
// The error-abort scenario runs only when LINE_FETCH_ERR_EN is defined.
`timescale 1ns/1ps
module tb_wb_line_fetcher;
   localparam int WORDS = 8;
   localparam int DEPTH = 4;
   localparam logic [31:0] PATTERN = 32'hA5A5_5A5A;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        i_start = 1'b0;
   logic [31:0] i_base_addr = 32'd0;
   logic        o_busy, o_done;
`ifdef LINE_FETCH_ERR_EN
   logic        i_wb_err = 1'b0;
   logic        o_err;
`endif

   wb_line_fetcher_if bus();

   wb_line_fetcher #(.WORDS_PER_LINE(WORDS), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .i_start(i_start),
      .i_base_addr(i_base_addr),
      .o_busy(o_busy),
      .o_done(o_done),
`ifdef LINE_FETCH_ERR_EN
      .i_wb_err(i_wb_err),
      .o_err(o_err),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int failures = 0;
   int cycle = 0;
   logic [31:0] addr_log[$];
   int          acc_cyc[$];
   logic [31:0] rx[$];
   int ack_total = 0, pop_total = 0, done_count = 0, err_count = 0, resp_count = 0;
   int last_ack_cyc = 0, done_cyc = 0, hold_errs = 0, hold_seen = 0, stb_viol = 0;
   int err_at = 0;
   bit stall_mode = 0, ready_en = 1, occ_check = 0;
   logic pending = 1'b0, prev_hold = 1'b0;
   logic [31:0] pend_addr = 32'd0, prev_addr = 32'd0;
   logic [31:0] wrap_exp[4];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic clearLogs();
      addr_log.delete();
      acc_cyc.delete();
      rx.delete();
      ack_total = 0; pop_total = 0; done_count = 0; err_count = 0; resp_count = 0;
      hold_errs = 0; hold_seen = 0; stb_viol = 0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [31:0] base);
      @(negedge clk); #2;
      clearLogs();
      i_base_addr = base;
      i_start = 1'b1;
      @(negedge clk); #2;
      i_start = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int limit);
      int n = 0;
      while (done_count == 0 && n < limit) begin
         @(negedge clk); #2;
         n++;
      end
      checkOutput({tag, " done seen"}, 32'(done_count != 0), 32'd1);
   endtask

   task automatic checkLine(input string tag, input logic [31:0] base);
      checkOutput({tag, " addr count"}, 32'(addr_log.size()), 32'(WORDS));
      checkOutput({tag, " rx count"}, 32'(rx.size()), 32'(WORDS));
      for (int i = 0; i < WORDS; i++) begin
         if (i < addr_log.size()) checkOutput($sformatf("%s addr%0d", tag, i), addr_log[i], base + 32'(4 * i));
         if (i < rx.size()) checkOutput($sformatf("%s word%0d", tag, i), rx[i], (base + 32'(4 * i)) ^ PATTERN);
      end
   endtask

   // Responder with one-cycle ack latency, optional alternating stall, and the pixel consumer.
   initial begin
      bus.i_wb_stall = 1'b0;
      bus.i_wb_ack = 1'b0;
      bus.i_wb_data = 32'd0;
      bus.i_pix_ready = 1'b0;
      forever begin
         @(negedge clk);
         cycle++;
         if (!reset_n) begin
            pending = 1'b0;
            prev_hold = 1'b0;
            bus.i_wb_ack = 1'b0;
            bus.i_wb_stall = 1'b0;
            ack_total = 0;
            pop_total = 0;
`ifdef LINE_FETCH_ERR_EN
            i_wb_err = 1'b0;
`endif
         end else begin
            if (occ_check && bus.o_wb_stb && (ack_total - pop_total) >= DEPTH) stb_viol++;
            if (prev_hold) begin
               hold_seen++;
               if (bus.o_wb_addr !== prev_addr || bus.o_wb_stb !== 1'b1) hold_errs++;
            end
            if (o_done) begin
               done_count++;
               done_cyc = cycle;
            end
`ifdef LINE_FETCH_ERR_EN
            if (o_err) err_count++;
            i_wb_err = 1'b0;
`endif
            bus.i_wb_ack = 1'b0;
            if (pending) begin
               resp_count++;
               if (resp_count == err_at) begin
`ifdef LINE_FETCH_ERR_EN
                  i_wb_err = 1'b1;
`endif
               end else begin
                  bus.i_wb_ack = 1'b1;
                  bus.i_wb_data = pend_addr ^ PATTERN;
                  ack_total++;
                  last_ack_cyc = cycle;
               end
            end
            bus.i_wb_stall = stall_mode ? ~bus.i_wb_stall : 1'b0;
            pending = bus.o_wb_cyc && bus.o_wb_stb && !bus.i_wb_stall;
            if (pending) begin
               addr_log.push_back(bus.o_wb_addr);
               acc_cyc.push_back(cycle);
               pend_addr = bus.o_wb_addr;
            end
            prev_hold = bus.o_wb_stb && bus.i_wb_stall;
            prev_addr = bus.o_wb_addr;
            bus.i_pix_ready = ready_en;
            if (bus.o_pix_valid && ready_en) begin
               rx.push_back(bus.o_pix_data);
               pop_total++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global timeout: observed running expected finished");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      wrap_exp[0] = 32'hFFFF_FFF8;
      wrap_exp[1] = 32'hFFFF_FFFC;
      wrap_exp[2] = 32'h0000_0000;
      wrap_exp[3] = 32'h0000_0004;

      #1 reset_n = 1'b0;
      #2;
      checkOutput("rst cyc", 32'(bus.o_wb_cyc), 32'd0);
      checkOutput("rst stb", 32'(bus.o_wb_stb), 32'd0);
      checkOutput("rst addr", bus.o_wb_addr, 32'd0);
      checkOutput("rst busy", 32'(o_busy), 32'd0);
      checkOutput("rst done", 32'(o_done), 32'd0);
      checkOutput("rst valid", 32'(bus.o_pix_valid), 32'd0);
      checkOutput("rst data", bus.o_pix_data, 32'd0);
      waitCycles(3);
      reset_n = 1'b1;
      waitCycles(2);

      // Zero-wait responder, consumer always ready
      applyStimulus(32'h0000_1000);
      checkOutput("start busy", 32'(o_busy), 32'd1);
      checkOutput("start cyc", 32'(bus.o_wb_cyc), 32'd1);
      checkOutput("start stb", 32'(bus.o_wb_stb), 32'd1);
      checkOutput("start addr", bus.o_wb_addr, 32'h0000_1000);
      checkOutput("start we", 32'(bus.o_wb_we), 32'd0);
      waitDone("zw", 100);
      checkOutput("zw done pulse", 32'(o_done), 32'd1);
      checkOutput("zw done busy", 32'(o_busy), 32'd0);
      checkOutput("zw done cyc", 32'(bus.o_wb_cyc), 32'd0);
      checkOutput("zw done latency", 32'(done_cyc - last_ack_cyc), 32'd1);
      if (acc_cyc.size() == WORDS) checkOutput("zw back-to-back", 32'(acc_cyc[WORDS-1] - acc_cyc[0]), 32'(WORDS - 1));
      waitCycles(4);
      checkLine("zw", 32'h0000_1000);
      checkOutput("zw done once", 32'(done_count), 32'd1);

      // Responder stalls every other cycle
      @(negedge clk); #2;
      stall_mode = 1;
      applyStimulus(32'h0000_2000);
      waitDone("stall", 200);
      stall_mode = 0;
      waitCycles(4);
      checkLine("stall", 32'h0000_2000);
      checkOutput("stall acks", 32'(ack_total), 32'(WORDS));
      checkOutput("stall hold errs", 32'(hold_errs), 32'd0);
      checkOutput("stall hold seen", 32'(hold_seen > 0), 32'd1);

      // Consumer backpressure fills the 4-entry FIFO
      @(negedge clk); #2;
      ready_en = 0;
      occ_check = 1;
      applyStimulus(32'h0000_3000);
      waitCycles(30);
      checkOutput("bp issued", 32'(addr_log.size()), 32'd4);
      checkOutput("bp stb low", 32'(bus.o_wb_stb), 32'd0);
      checkOutput("bp valid", 32'(bus.o_pix_valid), 32'd1);
      checkOutput("bp head", bus.o_pix_data, 32'h0000_3000 ^ PATTERN);
      checkOutput("bp busy", 32'(o_busy), 32'd1);
      ready_en = 1;
      waitDone("bp", 200);
      waitCycles(4);
      occ_check = 0;
      checkLine("bp", 32'h0000_3000);
      checkOutput("bp credit", 32'(stb_viol), 32'd0);

      // Address wrap at the top of the map
      applyStimulus(32'hFFFF_FFF8);
      waitDone("wrap", 100);
      waitCycles(4);
      for (int i = 0; i < 4; i++) begin
         if (i < addr_log.size()) checkOutput($sformatf("wrap addr%0d", i), addr_log[i], wrap_exp[i]);
      end

      // Re-pulsed start mid-line is ignored
      applyStimulus(32'h0000_4000);
      waitCycles(2);
      i_base_addr = 32'h0000_9000;
      i_start = 1'b1;
      waitCycles(1);
      i_start = 1'b0;
      waitDone("restart", 100);
      waitCycles(6);
      checkLine("restart", 32'h0000_4000);
      checkOutput("restart done once", 32'(done_count), 32'd1);
      checkOutput("restart idle", 32'(o_busy), 32'd0);

      // Reset in the middle of a line
      applyStimulus(32'h0000_5000);
      ready_en = 0;
      waitCycles(3);
      reset_n = 1'b0;
      #1;
      checkOutput("midrst cyc", 32'(bus.o_wb_cyc), 32'd0);
      checkOutput("midrst stb", 32'(bus.o_wb_stb), 32'd0);
      checkOutput("midrst valid", 32'(bus.o_pix_valid), 32'd0);
      checkOutput("midrst busy", 32'(o_busy), 32'd0);
      waitCycles(2);
      reset_n = 1'b1;
      ready_en = 1;
      waitCycles(2);
      applyStimulus(32'h0000_6000);
      waitDone("postrst", 100);
      waitCycles(4);
      checkLine("postrst", 32'h0000_6000);

`ifdef LINE_FETCH_ERR_EN
      // Bus error on the third response aborts the line
      @(negedge clk); #2;
      ready_en = 0;
      err_at = 3;
      applyStimulus(32'h0000_7000);
      waitCycles(20);
      checkOutput("err pulses", 32'(err_count), 32'd1);
      checkOutput("err no done", 32'(done_count), 32'd0);
      checkOutput("err cyc", 32'(bus.o_wb_cyc), 32'd0);
      checkOutput("err busy", 32'(o_busy), 32'd0);
      checkOutput("err head", bus.o_pix_data, 32'h0000_7000 ^ PATTERN);
      ready_en = 1;
      waitCycles(6);
      err_at = 0;
      checkOutput("err kept words", 32'(rx.size()), 32'd2);
      if (rx.size() > 1) checkOutput("err word1", rx[1], 32'h0000_7004 ^ PATTERN);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/wb_line_fetcher.md
# wb_line_fetcher

Pipelined Wishbone bus initiator that streams one video line from memory into a local FIFO for the VGA pixel path. Software or the timing generator pulses a start with a base address. The block then issues WORDS_PER_LINE sequential read requests on the shared bus, honouring stall, and buffers acknowledged data. A downstream valid/ready consumer drains the FIFO. It is the initiator-side counterpart to the bus responders (boot ROM, RAM) in the SoC.

## Interface

Parameters:
- WORDS_PER_LINE, 160, 32-bit words fetched per start (640 px at 8 bpp); 1..4095.
- FIFO_DEPTH, 16, line FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse: latch i_base_addr, begin a line.
- i_base_addr  in  32  byte address of first word; bits [1:0] ignored (treated as 0).
- o_busy  out  1  high from the cycle after accepted start until o_done.
- o_done  out  1  one-cycle pulse after the final ack of the line.
- o_wb_cyc  out  1  bus cycle held for the whole line.
- o_wb_stb  out  1  request strobe.
- o_wb_addr  out  32  request byte address, word aligned.
- o_wb_we  out  1  constant 0.
- i_wb_data  in  32  read data, valid with i_wb_ack.
- i_wb_stall  in  1  responder not accepting; request held.
- i_wb_ack  in  1  one response per accepted request, in order.
- o_pix_data  out  32  FIFO head word.
- o_pix_valid  out  1  FIFO non-empty.
- i_pix_ready  in  1  consumer pops head when valid & ready.

## Operation

- States: IDLE, REQ (requests remain to issue), DRAIN (all issued, acks outstanding).
- IDLE: i_start=1 → latch address, req_left=WORDS_PER_LINE, ack_left=WORDS_PER_LINE, go REQ. i_start ignored in REQ/DRAIN.
- Request accepted when o_wb_stb & !i_wb_stall. On acceptance: address += 4, req_left−1, in_flight+1.
- On i_wb_ack: push i_wb_data into FIFO, in_flight−1, ack_left−1.
- Credit rule: a new stb is raised only if in_flight + fifo_count < FIFO_DEPTH. Once raised, stb and o_wb_addr stay stable until accepted. The FIFO therefore never overflows; acks are always pushed.
- REQ → DRAIN when the last request is accepted (req_left reaches 0). DRAIN → IDLE when ack_left reaches 0. That cycle drops cyc and registers o_done=1.
- Address arithmetic is 32-bit, wrapping modulo 2^32 with no error.
- FIFO: show-ahead; simultaneous push and pop keeps the count unchanged. FIFO contents persist after o_done until drained, and may span into the next line.
- Acks with cyc=0 or in_flight=0 are ignored (no push).

## Timing

- Reset values: o_wb_cyc=0, o_wb_stb=0, o_wb_addr=0, o_busy=0, o_done=0, o_pix_valid=0, o_pix_data=0, FIFO empty, state IDLE. Reset mid-line drops cyc/stb asynchronously and discards the FIFO and counters.
- Start cycle T: o_busy, o_wb_cyc and o_wb_stb are all 1 at T+1, with o_wb_addr = base.
- With no stall, no backpressure and FIFO space, one request is accepted per cycle; back-to-back addresses are issued.
- Ack at cycle A: o_pix_valid=1 at A+1.
- Final ack at cycle F: o_done=1, o_busy=0 and o_wb_cyc=0 at F+1. The next i_start is accepted at F+1.
- All outputs are registered; there is no combinational path from Wishbone inputs to Wishbone outputs.

## Configuration

- LINE_FETCH_ERR_EN defined: adds port i_wb_err (in, 1) and output o_err (out, 1, reset 0).
  - i_wb_err while cyc=1 drops cyc/stb next cycle, flushes outstanding count, and returns to IDLE.
  - That cycle pulses o_err=1, with no o_done. FIFO data already pushed is kept.
- LINE_FETCH_ERR_EN undefined: neither port exists; the bus is assumed never to error.

## Test plan

- Zero-wait responder (ack one cycle after accept), WORDS_PER_LINE=8, base 0x1000, consumer always ready:
  - addresses 0x1000..0x101C are issued on 8 consecutive cycles;
  - o_pix_data outputs the memory words in order;
  - o_done occurs exactly once, one cycle after the 8th ack.
- Responder stalls every other cycle:
  - o_wb_addr is held stable while stalled;
  - no address is skipped or duplicated;
  - the total ack count is 8.
- Consumer ready=0, FIFO_DEPTH=4, WORDS_PER_LINE=8:
  - the 5th stb is never raised while 4 words sit in the FIFO;
  - releasing ready lets all 8 words arrive in order with no loss.
- Base 0xFFFFFFF8, 4 words: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- i_start re-pulsed mid-line and reset_n asserted mid-line:
  - the re-pulsed i_start is ignored;
  - on reset, cyc=0 immediately, o_pix_valid=0, and a new start after release fetches correctly.
- With LINE_FETCH_ERR_EN, i_wb_err on the 3rd response: o_err pulses once, cyc drops, 2 words remain in the FIFO, no o_done.
